// File: rtl/vx_bits_insert_pipe.sv
// Multi-lane registered bit-field inserter behind a 2-entry skid buffer with valid/ready handshake.
// Optional performance counters are built when VX_BITS_INSERT_PERF_EN is defined.
//
// state | meaning
// EMPTY | main register invalid, skid empty
// ONE   | main register valid, skid empty
// FULL  | main and skid valid, input stalled
module vx_bits_insert_pipe #(
  parameter int LANES   = 1,
  parameter int N       = 1,
  parameter int S       = 1,
  parameter int POS     = 0,
  parameter int TAG_GEN = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              valid_in,
  input  logic [LANES*N-1:0]                data_in,
  input  logic [LANES*((S>0)?S:1)-1:0]      sel_in,
  output logic                              ready_in,
  output logic                              valid_out,
  output logic [LANES*(N+S)-1:0]            data_out,
  input  logic                              ready_out,
  output logic [((S>0)?S:1)-1:0]            tag_cnt
`ifdef VX_BITS_INSERT_PERF_EN
  ,
  output logic [31:0]                       perf_stalls,
  output logic [31:0]                       perf_beats
`endif
);

  localparam int SW = (S > 0) ? S : 1;
  localparam int OW = N + S;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                 state_q, state_d;
  logic [LANES*OW-1:0]    main_q, main_d;
  logic [LANES*OW-1:0]    skid_q, skid_d;
  logic                   ready_q, ready_d;
  logic [LANES*OW-1:0]    ins_w;
  logic [LANES*SW-1:0]    field_w;
  logic [SW-1:0]          tag_w;
  logic                   accept;
  logic                   pop;
  logic                   unused_sel;

  if (POS < 0 || POS > N) begin : g_bad_pos
    $error("vx_bits_insert_pipe: POS must lie in 0..N");
  end

  assign accept     = valid_in && ready_q;
  assign pop        = (state_q != EMPTY) && ready_out;
  assign unused_sel = ^{sel_in, field_w};

  if (TAG_GEN != 0 && S > 0) begin : g_tag
    logic [SW-1:0] tag_q, tag_d;

    always_comb begin
      tag_d = tag_q;
      if (accept) tag_d = tag_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tag_q <= '0;
      else          tag_q <= tag_d;
    end

    assign tag_w = tag_q;
  end else begin : g_no_tag
    assign tag_w = '0;
  end

  // Insertion is purely a wiring permutation, resolved per output bit at elaboration.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign field_w[i*SW +: SW] = (TAG_GEN != 0) ? tag_w : sel_in[i*SW +: SW];
    for (genvar j = 0; j < OW; j++) begin : g_bit
      if (j < POS) begin : g_lo
        assign ins_w[i*OW + j] = data_in[i*N + j];
      end else if (j < POS + S) begin : g_fld
        assign ins_w[i*OW + j] = field_w[i*SW + j - POS];
      end else begin : g_hi
        assign ins_w[i*OW + j] = data_in[i*N + j - S];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = ins_w;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          skid_d  = ins_w;
          state_d = FULL;
        end else if (accept && pop) begin
          main_d  = ins_w;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_in  = ready_q;
  assign valid_out = (state_q != EMPTY);
  assign data_out  = main_q;
  assign tag_cnt   = tag_w;

`ifdef VX_BITS_INSERT_PERF_EN
  logic [31:0] stalls_q, stalls_d;
  logic [31:0] beats_q, beats_d;

  always_comb begin
    stalls_d = stalls_q;
    beats_d  = beats_q;
    if (valid_out && !ready_out && stalls_q != 32'hFFFF_FFFF) stalls_d = stalls_q + 32'd1;
    if (accept && beats_q != 32'hFFFF_FFFF)                    beats_d  = beats_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stalls_q <= '0;
      beats_q  <= '0;
    end else begin
      stalls_q <= stalls_d;
      beats_q  <= beats_d;
    end
  end

  assign perf_stalls = stalls_q;
  assign perf_beats  = beats_q;
`endif

endmodule

// File: tb/tb_vx_bits_insert_pipe.sv
// Scoreboard bench for vx_bits_insert_pipe: four builds (mid/LSB/MSB insert, tag generator, S=0).
// Expected words are pushed on accept; per-instance monitors pop and compare on every pop.
module tb_vx_bits_insert_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  // A: LANES=1 N=8 S=2 POS=3
  logic       a_vin, a_rdy, a_vout, a_rout;
  logic [7:0] a_din;
  logic [1:0] a_sel, a_tag;
  logic [9:0] a_dout;
  // B: LANES=4 N=8 S=2 POS=0 TAG_GEN=1
  logic        b_vin, b_rdy, b_vout, b_rout;
  logic [31:0] b_din;
  logic [7:0]  b_sel;
  logic [39:0] b_dout;
  logic [1:0]  b_tag;
  // C: LANES=2 N=8 S=3 POS=8
  logic        c_vin, c_rdy, c_vout, c_rout;
  logic [15:0] c_din;
  logic [5:0]  c_sel;
  logic [21:0] c_dout;
  logic [2:0]  c_tag;
  // D: LANES=2 N=8 S=0
  logic        d_vin, d_rdy, d_vout, d_rout;
  logic [15:0] d_din;
  logic [1:0]  d_sel;
  logic [15:0] d_dout;
  logic [0:0]  d_tag;
`ifdef VX_BITS_INSERT_PERF_EN
  logic [31:0] a_ps, a_pb, b_ps, b_pb, c_ps, c_pb, d_ps, d_pb;
`endif

  vx_bits_insert_pipe #(.LANES(1), .N(8), .S(2), .POS(3), .TAG_GEN(0)) u_a (
    .clk(clk), .reset_n(rst_n), .valid_in(a_vin), .data_in(a_din), .sel_in(a_sel),
    .ready_in(a_rdy), .valid_out(a_vout), .data_out(a_dout), .ready_out(a_rout), .tag_cnt(a_tag)
`ifdef VX_BITS_INSERT_PERF_EN
    , .perf_stalls(a_ps), .perf_beats(a_pb)
`endif
  );

  vx_bits_insert_pipe #(.LANES(4), .N(8), .S(2), .POS(0), .TAG_GEN(1)) u_b (
    .clk(clk), .reset_n(rst_n), .valid_in(b_vin), .data_in(b_din), .sel_in(b_sel),
    .ready_in(b_rdy), .valid_out(b_vout), .data_out(b_dout), .ready_out(b_rout), .tag_cnt(b_tag)
`ifdef VX_BITS_INSERT_PERF_EN
    , .perf_stalls(b_ps), .perf_beats(b_pb)
`endif
  );

  vx_bits_insert_pipe #(.LANES(2), .N(8), .S(3), .POS(8), .TAG_GEN(0)) u_c (
    .clk(clk), .reset_n(rst_n), .valid_in(c_vin), .data_in(c_din), .sel_in(c_sel),
    .ready_in(c_rdy), .valid_out(c_vout), .data_out(c_dout), .ready_out(c_rout), .tag_cnt(c_tag)
`ifdef VX_BITS_INSERT_PERF_EN
    , .perf_stalls(c_ps), .perf_beats(c_pb)
`endif
  );

  vx_bits_insert_pipe #(.LANES(2), .N(8), .S(0), .POS(0), .TAG_GEN(0)) u_d (
    .clk(clk), .reset_n(rst_n), .valid_in(d_vin), .data_in(d_din), .sel_in(d_sel),
    .ready_in(d_rdy), .valid_out(d_vout), .data_out(d_dout), .ready_out(d_rout), .tag_cnt(d_tag)
`ifdef VX_BITS_INSERT_PERF_EN
    , .perf_stalls(d_ps), .perf_beats(d_pb)
`endif
  );

  logic [9:0]  qa[$];
  logic [39:0] qb[$];
  logic [21:0] qc[$];
  logic [15:0] qd[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic no_exp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output beat with empty scoreboard", name);
  endtask

  function automatic logic [9:0] ins_a(input logic [7:0] d, input logic [1:0] s);
    return {d[7:3], s, d[2:0]};
  endfunction

  // Monitors
  logic       hold_a;
  logic [9:0] hold_dat;
  int         tb_stalls, tb_beats;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete(); qc.delete(); qd.delete();
      hold_a    = 1'b0;
      tb_stalls = 0;
      tb_beats  = 0;
    end else begin
      if (hold_a) begin
        chk("a_hold_valid", a_vout, 1);
        chk("a_hold_data", a_dout, hold_dat);
      end
      if (a_vout && a_rout) begin
        if (qa.size() == 0) no_exp("a_data");
        else chk("a_data", a_dout, qa.pop_front());
      end
      if (b_vout && b_rout) begin
        if (qb.size() == 0) no_exp("b_data");
        else chk("b_data", b_dout, qb.pop_front());
      end
      if (c_vout && c_rout) begin
        if (qc.size() == 0) no_exp("c_data");
        else chk("c_data", c_dout, qc.pop_front());
      end
      if (d_vout && d_rout) begin
        if (qd.size() == 0) no_exp("d_data");
        else chk("d_data", d_dout, qd.pop_front());
      end
      hold_a   = a_vout && !a_rout;
      hold_dat = a_dout;
      if (a_vout && !a_rout) tb_stalls++;
      if (a_vin && a_rdy)    tb_beats++;
    end
  end

  task automatic step_a(input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic ro, input logic [9:0] e, output logic acc);
    @(posedge clk); #1;
    a_vin = v; a_din = d; a_sel = s; a_rout = ro;
    @(negedge clk);
    acc = rst_n && v && a_rdy;
    if (acc) qa.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [1:0] tk;
    logic [7:0] rd;
    logic [1:0] rs;

    rst_n = 1'b0;
    a_vin = 0; a_din = 0; a_sel = 0; a_rout = 0;
    b_vin = 0; b_din = 0; b_sel = 0; b_rout = 1;
    c_vin = 0; c_din = 0; c_sel = 0; c_rout = 1;
    d_vin = 0; d_din = 0; d_sel = 0; d_rout = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", a_vout, 0);
    chk("rst_data_out", a_dout, 0);
    chk("rst_ready_in", a_rdy, 1);
    chk("rst_tag_a", a_tag, 0);
    chk("rst_tag_b", b_tag, 0);
    rst_n = 1'b1;

    // T1
    step_a(1, 8'hA5, 2'b10, 1, 10'b1010010101, acc);
    chk("t1_accept", acc, 1);
    step_a(0, 8'h00, 2'b00, 1, 10'd0, acc);
    chk("t1_latency", a_vout, 1);
    step_a(0, 8'h00, 2'b00, 1, 10'd0, acc);
    chk("t1_drained", a_vout, 0);

    // T2
    step_a(1, 8'h3C, 2'b01, 0, ins_a(8'h3C, 2'b01), acc);
    chk("t2_acc1", acc, 1);
    step_a(1, 8'hC3, 2'b11, 0, ins_a(8'hC3, 2'b11), acc);
    chk("t2_acc2", acc, 1);
    step_a(1, 8'h5A, 2'b00, 0, ins_a(8'h5A, 2'b00), acc);
    chk("t2_acc3_blocked", acc, 0);
    chk("t2_ready_low", a_rdy, 0);
    step_a(1, 8'h5A, 2'b00, 1, ins_a(8'h5A, 2'b00), acc);
    chk("t2_ready_low_at_pop", a_rdy, 0);
    step_a(1, 8'h5A, 2'b00, 1, ins_a(8'h5A, 2'b00), acc);
    chk("t2_ready_after_pop", a_rdy, 1);
    chk("t2_acc3", acc, 1);
    repeat (3) step_a(0, 8'h00, 2'b00, 1, 10'd0, acc);
    chk("t2_queue_drained", qa.size(), 0);

    // T3 / T4
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      b_vin = 1; b_din = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)}; b_sel = 8'hFF;
      c_vin = 1; c_din = {8'(8'hA0 + k), 8'(8'h0F * k)}; c_sel = 6'(k * 7 + 5);
      d_vin = 1; d_din = 16'(16'h1234 * (k + 1)); d_sel = 2'b11;
      @(negedge clk);
      tk = k[1:0];
      chk("t3_b_ready", b_rdy, 1);
      if (b_rdy) qb.push_back({b_din[31:24], tk, b_din[23:16], tk, b_din[15:8], tk, b_din[7:0], tk});
      if (c_rdy) qc.push_back({c_sel[5:3], c_din[15:8], c_sel[2:0], c_din[7:0]});
      if (d_rdy) qd.push_back(d_din);
      if (k == 1) chk("t4_d_latency", d_vout, 1);
    end
    @(posedge clk); #1;
    b_vin = 0; c_vin = 0; d_vin = 0;
    repeat (2) @(negedge clk);
    chk("t3_tag_end", b_tag, 2);
    chk("t4_c_tag_zero", c_tag, 0);
    chk("t4_d_tag_zero", d_tag, 0);
    chk("t34_queues_drained", qb.size() + qc.size() + qd.size(), 0);

    // T5
    step_a(1, 8'h11, 2'b01, 0, ins_a(8'h11, 2'b01), acc);
    step_a(1, 8'h22, 2'b10, 0, ins_a(8'h22, 2'b10), acc);
    step_a(0, 8'h00, 2'b00, 0, 10'd0, acc);
    chk("t5_full", a_rdy, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_out", a_vout, 0);
    chk("t5_ready_in", a_rdy, 1);
    chk("t5_data_out", a_dout, 0);
    chk("t5_tag_b", b_tag, 0);
    a_vin = 0; a_rout = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step_a(1, 8'h77, 2'b11, 1, ins_a(8'h77, 2'b11), acc);
    chk("t5_accept_after_reset", acc, 1);

    // T6
    for (int i = 0; i < 10000; i++) begin
      rd = 8'($urandom);
      rs = 2'($urandom);
      step_a(1'($urandom_range(0, 1)), rd, rs, 1'($urandom_range(0, 1)), ins_a(rd, rs), acc);
    end
    repeat (4) step_a(0, 8'h00, 2'b00, 1, 10'd0, acc);
    chk("t6_queue_drained", qa.size(), 0);
`ifdef VX_BITS_INSERT_PERF_EN
    chk("t6_perf_stalls", a_ps, 32'(tb_stalls));
    chk("t6_perf_beats", a_pb, 32'(tb_beats));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
